// File: rtl/ddr2_pkg.sv
// Shared DDR2 definitions: command-bus encodings, scheduler state encoding
// and small helpers used by the refresh scheduler slice.
package ddr2_pkg;

   // {cs_bar, ras_bar, cas_bar, we_bar}
   typedef enum logic [3:0] {
      CMD_NOP       = 4'b0111,
      CMD_PRECHARGE = 4'b0010,
      CMD_REFRESH   = 4'b0001,
      CMD_ACTIVATE  = 4'b0011,
      CMD_READ      = 4'b0101,
      CMD_WRITE     = 4'b0100
   } ddr2_cmd_e;

   typedef enum logic [2:0] {
      ST_WAIT_INIT = 3'd0,
      ST_IDLE      = 3'd1,
      ST_GRANTED   = 3'd2,
      ST_PRE_ALL   = 3'd3,
      ST_WAIT_RP   = 3'd4,
      ST_REFRESH   = 3'd5,
      ST_WAIT_RFC  = 3'd6
   } sched_state_e;

   // Width of the owed-refresh count seen outside the scheduler.
   localparam int OWED_W = 4;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ddr2_refresh_scheduler_if.sv
// Signal bundle between the refresh scheduler and its neighbours: command
// FIFO status, transaction-engine handshake and the DRAM command-bus mux.
interface ddr2_refresh_scheduler_if;
   import ddr2_pkg::*;

   logic              init_done;
   logic              cmd_pending;
   logic              engine_done;
   logic              grant_cmd;
   logic              bus_own;
   logic              cs_bar;
   logic              ras_bar;
   logic              cas_bar;
   logic              we_bar;
   logic              a10;
   logic [OWED_W-1:0] refresh_owed;
   logic              ref_overflow;

   // Side that drives the status/handshake inputs and consumes the bus.
   modport master (
      output init_done, cmd_pending, engine_done,
      input  grant_cmd, bus_own, cs_bar, ras_bar, cas_bar, we_bar, a10,
             refresh_owed, ref_overflow
   );

   // The refresh scheduler itself.
   modport slave (
      input  init_done, cmd_pending, engine_done,
      output grant_cmd, bus_own, cs_bar, ras_bar, cas_bar, we_bar, a10,
             refresh_owed, ref_overflow
   );

endinterface

// File: rtl/ddr2_refi_timer.sv
// Refresh-interval bookkeeping: interval counter, count of owed refreshes
// (saturating one above the postpone limit), sticky overflow and urgency.
module ddr2_refi_timer
   import ddr2_pkg::*;
#(
   parameter int TREFI_CYC    = 1560,
   parameter int MAX_POSTPONE = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_init_done,
   input  logic              i_refresh_issued,
   output logic [OWED_W-1:0] o_refresh_owed,
   output logic              o_ref_overflow,
   output logic              o_urgent
);

   localparam int                TMR_W    = $clog2(TREFI_CYC);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TREFI_CYC - 1);
   localparam logic [OWED_W-1:0] OWED_SAT = OWED_W'(MAX_POSTPONE + 1);
   localparam logic [OWED_W-1:0] OWED_URG = OWED_W'(MAX_POSTPONE);

   logic [TMR_W-1:0]  r_timer;
   logic [OWED_W-1:0] r_owed;
   logic              r_overflow;
   logic              w_tick;

   assign w_tick = i_init_done && (r_timer == TMR_LAST);

   // Interval counter: runs only once the DRAM is initialised, wraps on tick.
   always_ff @(posedge clk) begin
      if (reset)
         r_timer <= '0;
      else if (i_init_done)
         r_timer <= w_tick ? '0 : r_timer + TMR_W'(1);
   end

   // Owed count: +1 per tick, -1 per issued REFRESH, net zero when both coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_owed     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_tick && (r_owed == OWED_SAT))
            r_overflow <= 1'b1;
         if (w_tick && !i_refresh_issued) begin
            if (r_owed != OWED_SAT)
               r_owed <= r_owed + OWED_W'(1);
         end else if (!w_tick && i_refresh_issued && (r_owed != '0)) begin
            r_owed <= r_owed - OWED_W'(1);
         end
      end
   end

   assign o_refresh_owed = r_owed;
   assign o_ref_overflow = r_overflow;
   assign o_urgent       = (r_owed >= OWED_URG);

endmodule

// File: rtl/ddr2_refresh_scheduler.sv
// DDR2 refresh scheduler: on each idle opportunity either grants the next
// host command to the transaction engine or takes the command bus for a
// PRECHARGE-ALL + REFRESH sequence. All outputs are registered and aligned
// with the state they belong to.
module ddr2_refresh_scheduler
   import ddr2_pkg::*;
#(
   parameter int TREFI_CYC    = 1560,
   parameter int TRFC_CYC     = 26,
   parameter int TRP_CYC      = 3,
   parameter int MAX_POSTPONE = 8
) (
   input logic                      clk,
   input logic                      reset,
   ddr2_refresh_scheduler_if.slave  io_sch
);

   localparam int                WAIT_W   = $clog2(max2(TRFC_CYC, TRP_CYC) + 1);
   localparam logic [WAIT_W-1:0] RP_LOAD  = WAIT_W'(TRP_CYC - 1);
   localparam logic [WAIT_W-1:0] RFC_LOAD = WAIT_W'(TRFC_CYC - 1);

   sched_state_e      r_state;
   sched_state_e      w_next_state;
   logic [WAIT_W-1:0] r_wait;
   logic              w_grant;
   logic              w_bus_own;
   logic [3:0]        w_cmd;
   logic              w_a10;
   logic              r_grant;
   logic              r_bus_own;
   logic [3:0]        r_cmd;
   logic              r_a10;
   logic [OWED_W-1:0] w_owed;
   logic              w_overflow;
   logic              w_urgent;
   logic              w_refresh_issued;

   assign w_refresh_issued = (r_state == ST_REFRESH);

   ddr2_refi_timer #(
      .TREFI_CYC    (TREFI_CYC),
      .MAX_POSTPONE (MAX_POSTPONE)
   ) u_refi_timer (
      .clk              (clk),
      .reset            (reset),
      .i_init_done      (io_sch.init_done),
      .i_refresh_issued (w_refresh_issued),
      .o_refresh_owed   (w_owed),
      .o_ref_overflow   (w_overflow),
      .o_urgent         (w_urgent)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_WAIT_INIT;
      else
         r_state <= w_next_state;
   end

   // Next-state decision, grant pulse, and the bus command for the next state.
   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      unique case (r_state)
         ST_WAIT_INIT: if (io_sch.init_done) w_next_state = ST_IDLE;
         ST_IDLE: begin
            if ((w_owed != '0) && (w_urgent || !io_sch.cmd_pending)) begin
               w_next_state = ST_PRE_ALL;
            end else if (io_sch.cmd_pending) begin
               w_next_state = ST_GRANTED;
               w_grant      = 1'b1;
            end
         end
         ST_GRANTED:  if (io_sch.engine_done) w_next_state = ST_IDLE;
         ST_PRE_ALL:  w_next_state = ST_WAIT_RP;
         ST_WAIT_RP:  if (r_wait == '0) w_next_state = ST_REFRESH;
         ST_REFRESH:  w_next_state = ST_WAIT_RFC;
         ST_WAIT_RFC: if (r_wait == '0) w_next_state = ST_IDLE;
         default:     w_next_state = ST_WAIT_INIT;
      endcase

      w_bus_own = 1'b0;
      w_cmd     = CMD_NOP;
      w_a10     = 1'b0;
      unique case (w_next_state)
         ST_PRE_ALL: begin
            w_bus_own = 1'b1;
            w_cmd     = CMD_PRECHARGE;
            w_a10     = 1'b1;
         end
         ST_REFRESH: begin
            w_bus_own = 1'b1;
            w_cmd     = CMD_REFRESH;
         end
         ST_WAIT_RP, ST_WAIT_RFC: w_bus_own = 1'b1;
         default: ;
      endcase
   end

   // Shared wait counter: loaded on entry to each wait state, counts to zero.
   always_ff @(posedge clk) begin
      if (reset)
         r_wait <= '0;
      else if ((w_next_state == ST_WAIT_RP) && (r_state != ST_WAIT_RP))
         r_wait <= RP_LOAD;
      else if ((w_next_state == ST_WAIT_RFC) && (r_state != ST_WAIT_RFC))
         r_wait <= RFC_LOAD;
      else if (r_wait != '0)
         r_wait <= r_wait - WAIT_W'(1);
   end

   // Output registers so the bus mux and command pins see glitch-free values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant   <= 1'b0;
         r_bus_own <= 1'b0;
         r_cmd     <= CMD_NOP;
         r_a10     <= 1'b0;
      end else begin
         r_grant   <= w_grant;
         r_bus_own <= w_bus_own;
         r_cmd     <= w_cmd;
         r_a10     <= w_a10;
      end
   end

   assign io_sch.grant_cmd    = r_grant;
   assign io_sch.bus_own      = r_bus_own;
   assign io_sch.cs_bar       = r_cmd[3];
   assign io_sch.ras_bar      = r_cmd[2];
   assign io_sch.cas_bar      = r_cmd[1];
   assign io_sch.we_bar       = r_cmd[0];
   assign io_sch.a10          = r_a10;
   assign io_sch.refresh_owed = w_owed;
   assign io_sch.ref_overflow = w_overflow;

endmodule

// File: tb/tb_ddr2_refresh_scheduler.sv
// Bench for ddr2_refresh_scheduler: directed scenarios followed by random
// stimulus, every cycle compared against a command-sequence reference model.
module tb_ddr2_refresh_scheduler;
   import ddr2_pkg::*;

   localparam int TREFI = 20;
   localparam int TRFC  = 5;
   localparam int TRP   = 2;
   localparam int MAXP  = 2;

   // Expected {cs,ras,cas,we,a10} words.
   localparam logic [4:0] E_NOP = 5'b0111_0;
   localparam logic [4:0] E_PRE = 5'b0010_1;
   localparam logic [4:0] E_REF = 5'b0001_0;

   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   ddr2_refresh_scheduler_if sif ();

   ddr2_refresh_scheduler #(
      .TREFI_CYC    (TREFI),
      .TRFC_CYC     (TRFC),
      .TRP_CYC      (TRP),
      .MAX_POSTPONE (MAXP)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .io_sch (sif.slave)
   );

   // Reference model: refresh is an explicit list of bus words to play out.
   int         m_timer;
   int         m_owed;
   bit         m_ovf;
   bit         m_init;
   bit         m_busy;
   bit         m_grant;
   bit         m_bus;
   logic [4:0] m_cur;
   logic [4:0] m_q[$];

   task automatic model_edge();
      bit tick;
      bit issued;
      int owed_old;
      if (reset) begin
         m_timer = 0; m_owed = 0; m_ovf = 0; m_init = 0; m_busy = 0;
         m_grant = 0; m_bus = 0; m_cur = E_NOP; m_q.delete();
         return;
      end
      tick   = sif.init_done && (m_timer == TREFI - 1);
      if (sif.init_done) m_timer = (m_timer + 1) % TREFI;
      issued   = m_bus && (m_cur == E_REF);
      owed_old = m_owed;
      if (tick && owed_old == MAXP + 1) m_ovf = 1;
      if (tick && !issued)
         m_owed = (owed_old < MAXP + 1) ? owed_old + 1 : owed_old;
      else if (issued && !tick && owed_old > 0)
         m_owed = owed_old - 1;
      m_grant = 0;
      if (!m_init) begin
         m_init = sif.init_done;
      end else if (m_bus) begin
         if (m_q.size() > 0) m_cur = m_q.pop_front();
         else begin m_bus = 0; m_cur = E_NOP; end
      end else if (m_busy) begin
         if (sif.engine_done) m_busy = 0;
      end else if (owed_old > 0 && (owed_old >= MAXP || !sif.cmd_pending)) begin
         m_bus = 1;
         m_cur = E_PRE;
         m_q.delete();
         repeat (TRP) m_q.push_back(E_NOP);
         m_q.push_back(E_REF);
         repeat (TRFC) m_q.push_back(E_NOP);
      end else if (sif.cmd_pending) begin
         m_grant = 1;
         m_busy  = 1;
      end
   endtask

   function automatic logic [11:0] obs_vec();
      return {sif.grant_cmd, sif.bus_own, sif.cs_bar, sif.ras_bar, sif.cas_bar,
              sif.we_bar, sif.a10, sif.refresh_owed, sif.ref_overflow};
   endfunction

   function automatic logic [11:0] exp_vec();
      return {m_grant, m_bus, m_cur, 4'(m_owed), m_ovf};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_outputs", 16'(obs_vec()), 16'(exp_vec()));
   endtask

   logic [4:0] seq [9];
   bit         grant_seen;
   bit         saw_urgent;
   bit         found;
   int         grants_after;
   int         age;

   initial begin
      seq[0] = E_PRE; seq[1] = E_NOP; seq[2] = E_NOP; seq[3] = E_REF;
      for (int i = 4; i < 9; i++) seq[i] = E_NOP;

      reset = 1'b1;
      sif.init_done   = 1'b0;
      sif.cmd_pending = 1'b0;
      sif.engine_done = 1'b0;
      step();
      step();
      chk("reset_state", 16'(obs_vec()), 16'({2'b00, 4'b0111, 1'b0, 4'd0, 1'b0}));

      // 1: no activity before init completes
      reset = 1'b0;
      sif.cmd_pending = 1'b1;
      grant_seen = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         grant_seen |= sif.grant_cmd;
      end
      chk("t1_no_grant", 16'(grant_seen), 16'd0);
      chk("t1_idle_bus", 16'({sif.bus_own, sif.refresh_owed}), 16'd0);

      // 2: first tick and a full refresh sequence
      sif.cmd_pending = 1'b0;
      sif.init_done   = 1'b1;
      for (int i = 1; i < 20; i++) step();
      chk("t2_pre_tick", 16'(sif.refresh_owed), 16'd0);
      step();
      chk("t2_tick", 16'(sif.refresh_owed), 16'd1);
      for (int i = 0; i < 9; i++) begin
         step();
         chk("t2_seq", 16'({sif.bus_own, sif.cs_bar, sif.ras_bar, sif.cas_bar, sif.we_bar, sif.a10}),
             16'({1'b1, seq[i]}));
      end
      step();
      chk("t2_release", 16'({sif.bus_own, sif.refresh_owed}), 16'd0);

      // 3: grants with slow engine, urgent refresh pre-empts pending commands
      sif.cmd_pending = 1'b1;
      saw_urgent   = 0;
      grants_after = 0;
      age          = 0;
      for (int i = 0; i < 150; i++) begin
         sif.engine_done = m_busy && (age >= 30);
         step();
         if (m_grant) age = 0;
         else if (m_busy) age++;
         if (sif.bus_own && {sif.cs_bar, sif.ras_bar, sif.cas_bar, sif.we_bar} == 4'b0010)
            saw_urgent = 1;
         if (saw_urgent && sif.grant_cmd) grants_after++;
      end
      sif.engine_done = 1'b0;
      chk("t3_urgent_refresh", 16'(saw_urgent), 16'd1);
      chk("t3_grant_resumes", 16'(grants_after > 0), 16'd1);

      // 4: REFRESH issued on the same edge as a tick
      reset = 1'b1; sif.init_done = 1'b0; sif.cmd_pending = 1'b0;
      step();
      reset = 1'b0; sif.init_done = 1'b1; sif.cmd_pending = 1'b1;
      step();
      step();
      chk("t4_grant", 16'(sif.grant_cmd), 16'd1);
      for (int e = 3; e < 35; e++) step();
      sif.engine_done = 1'b1;
      step();
      sif.engine_done = 1'b0;
      sif.cmd_pending = 1'b0;
      step();
      chk("t4_pre", 16'({sif.bus_own, sif.cs_bar, sif.ras_bar, sif.cas_bar, sif.we_bar, sif.a10}),
          16'({1'b1, E_PRE}));
      step(); step(); step();
      chk("t4_ref_state", 16'({sif.cs_bar, sif.ras_bar, sif.cas_bar, sif.we_bar, sif.refresh_owed}),
          16'({4'b0001, 4'd1}));
      step();
      chk("t4_owed_held", 16'(sif.refresh_owed), 16'd1);

      // 5: engine holds the bus past the postpone limit
      reset = 1'b1; sif.init_done = 1'b0; sif.cmd_pending = 1'b0;
      step();
      reset = 1'b0; sif.init_done = 1'b1; sif.cmd_pending = 1'b1;
      step();
      step();
      sif.cmd_pending = 1'b0;
      for (int e = 3; e <= 85; e++) begin
         step();
         if (e == 20) chk("t5_owed_20", 16'({sif.refresh_owed, sif.ref_overflow}), 16'({4'd1, 1'b0}));
         if (e == 40) chk("t5_owed_40", 16'({sif.refresh_owed, sif.ref_overflow}), 16'({4'd2, 1'b0}));
         if (e == 60) chk("t5_owed_60", 16'({sif.refresh_owed, sif.ref_overflow}), 16'({4'd3, 1'b0}));
         if (e == 80) chk("t5_overflow", 16'({sif.refresh_owed, sif.ref_overflow}), 16'({4'd3, 1'b1}));
      end
      sif.engine_done = 1'b1;
      step();
      sif.engine_done = 1'b0;

      // 6: reset in the middle of WAIT_RFC
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         step();
         found = m_bus && (m_cur == E_NOP) && (m_q.size() < TRFC);
      end
      chk("t6_reached_rfc", 16'({found, sif.bus_own}), 16'({1'b1, 1'b1}));
      reset = 1'b1; sif.init_done = 1'b0;
      step();
      chk("t6_reset_outputs", 16'(obs_vec()), 16'({2'b00, 4'b0111, 1'b0, 4'd0, 1'b0}));
      chk("t6_reset_state", 16'(dut.r_state), 16'(ST_WAIT_INIT));
      reset = 1'b0; sif.init_done = 1'b1; sif.cmd_pending = 1'b1;
      step();
      chk("t6_no_early_grant", 16'(sif.grant_cmd), 16'd0);
      step();
      chk("t6_grant_after_init", 16'(sif.grant_cmd), 16'd1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         reset           = ($urandom_range(0, 199) == 0);
         sif.init_done   = ($urandom_range(0, 49) != 0);
         sif.cmd_pending = $urandom_range(0, 1);
         sif.engine_done = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
